int_res_addr_seq: RTL

// - Parametrised address sequencer for the CIM intermediate-result memory; successor to fixed per-step address constants.
// - Given base address, 2-D tile shape, row stride, data width and scan order, issues one bank-decoded word request per accepted cycle.
// - Sits between the inference-step controller and the int-res bank interface. Handles tiles that straddle bank boundaries.

---
 rtl/int_res_addr_seq_pkg.sv | 38 +++
 rtl/int_res_bank_decode.sv | 44 ++++
 rtl/int_res_addr_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/int_res_addr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_res_addr_seq_pkg
// Brief    : Shared types and sizing for the int-res address sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package int_res_addr_seq_pkg;

    localparam int c_NUM_BANKS = 4;
    localparam int c_BANK_SIZE = 14336;
    localparam int c_MAX_DIM   = 64;
    localparam int c_ADDR_W    = $clog2(c_NUM_BANKS * c_BANK_SIZE);

    // Words occupied by one tile element
    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    // Vector length selector shared with the inference-step controller
    typedef enum logic [1:0] {
        VLEN_16  = 2'd0,
        VLEN_32  = 2'd1,
        VLEN_64  = 2'd2,
        VLEN_128 = 2'd3
    } VectorLen_t;

    // Tile traversal order; the named dimension is the outer loop
    typedef enum logic {
        ROW_MAJOR = 1'b0,
        COL_MAJOR = 1'b1
    } ScanOrder_t;

    // Flat address over all banks, sized from total int-res capacity
    typedef logic [c_ADDR_W-1:0] IntResAddr_t;

endpackage
`default_nettype wire

// File: rtl/int_res_bank_decode.sv
`default_nettype none
// ============================================================================
// Module   : int_res_bank_decode
// Brief    : Combinational flat-address to {bank, in-bank address} decode.
//            Bank size need not be a power of two; a comparator chain picks
//            the highest bank whose base is not above the address.
// Revision : 1.0 - initial release
// ============================================================================
module int_res_bank_decode #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_SIZE = 14336,
    parameter int ADDR_W    = $clog2(NUM_BANKS * BANK_SIZE),
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int BADDR_W   = $clog2(BANK_SIZE)
) (
    input  logic [ADDR_W-1:0]  flat_addr,
    output logic [BANK_W-1:0]  bank,
    output logic [BADDR_W-1:0] bank_addr
);

    logic [ADDR_W-1:0]    w_bank_base [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_ge;
    logic [ADDR_W-1:0]    w_off;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank_cmp
        assign w_bank_base[k] = ADDR_W'(k * BANK_SIZE);
        assign w_ge[k]        = (flat_addr >= w_bank_base[k]);
    end

    // Highest bank whose base lies at or below the address wins
    always_comb begin
        bank  = '0;
        w_off = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (w_ge[k]) begin
                bank  = BANK_W'(k);
                w_off = w_bank_base[k];
            end
        end
        bank_addr = BADDR_W'(flat_addr - w_off);
    end

endmodule
`default_nettype wire

// File: rtl/int_res_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : int_res_addr_seq
// Brief    : Tile address sequencer for the CIM intermediate-result memory.
//            Range-checks a 2-D tile, then issues one bank-decoded request
//            per element with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module int_res_addr_seq
    import int_res_addr_seq_pkg::*;
#(
    parameter int NUM_BANKS = c_NUM_BANKS,
    parameter int BANK_SIZE = c_BANK_SIZE,
    parameter int MAX_DIM   = c_MAX_DIM,
    parameter int ADDR_W    = $clog2(NUM_BANKS * BANK_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [$clog2(MAX_DIM+1)-1:0]   num_rows,
    input  logic [$clog2(MAX_DIM+1)-1:0]   num_cols,
    input  logic [ADDR_W-1:0]              row_stride,
    input  DataWidth_t                     width,
    input  ScanOrder_t                     order,
    output logic                           req_valid,
    input  logic                           req_ready,
    output logic [$clog2(NUM_BANKS)-1:0]   req_bank,
    output logic [$clog2(BANK_SIZE)-1:0]   req_addr,
    output logic                           req_last,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int c_DIM_W   = $clog2(MAX_DIM + 1);
    localparam int c_BANK_W  = $clog2(NUM_BANKS);
    localparam int c_BADDR_W = $clog2(BANK_SIZE);
    // Wide enough for base + ((rows-1)*stride + cols)*2 without overflow
    localparam int c_CHK_W   = ADDR_W + c_DIM_W + 2;
    localparam int c_TOTAL   = NUM_BANKS * BANK_SIZE;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_CHECK  = 2'd1;
    localparam logic [1:0] c_S_ISSUE  = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    logic [1:0]            r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_base, r_stride;
    logic [c_DIM_W-1:0]    r_rows, r_cols;
    DataWidth_t            r_width;
    ScanOrder_t            r_order;
    logic [c_DIM_W-1:0]    r_inner, r_outer;
    logic [ADDR_W-1:0]     r_line, r_cur;
    logic                  r_valid, r_last, r_busy, r_done, r_err;
    logic [c_BANK_W-1:0]   r_bank;
    logic [c_BADDR_W-1:0]  r_baddr;

    logic                  w_double, w_row_major, w_empty, w_oob, w_xfer;
    logic [ADDR_W-1:0]     w_elem_step, w_stride_step, w_inner_step, w_outer_step;
    logic [c_DIM_W-1:0]    w_inner_max, w_outer_max;
    logic [c_CHK_W-1:0]    w_ext, w_end;
    logic                  w_inner_end, w_next_last;
    logic [c_DIM_W-1:0]    w_next_inner, w_next_outer;
    logic [ADDR_W-1:0]     w_line_step, w_next_line, w_next_cur, w_load_addr;
    logic [c_BANK_W-1:0]   w_dec_bank;
    logic [c_BADDR_W-1:0]  w_dec_baddr;

    // Loop geometry: steps and trip counts for the chosen scan order
    always_comb begin
        w_double      = (r_width == DOUBLE_WIDTH);
        w_row_major   = (r_order == ROW_MAJOR);
        w_elem_step   = w_double ? ADDR_W'(2) : ADDR_W'(1);
        w_stride_step = w_double ? {r_stride[ADDR_W-2:0], 1'b0} : r_stride;
        w_inner_step  = w_row_major ? w_elem_step   : w_stride_step;
        w_outer_step  = w_row_major ? w_stride_step : w_elem_step;
        w_inner_max   = w_row_major ? r_cols : r_rows;
        w_outer_max   = w_row_major ? r_rows : r_cols;
        w_empty       = (r_rows == '0) || (r_cols == '0);
        // Last word touched by the tile; the only multiply, used in CHECK
        w_ext = (c_CHK_W'(r_rows) - c_CHK_W'(1)) * c_CHK_W'(r_stride)
              + c_CHK_W'(r_cols) - c_CHK_W'(1);
        w_end = c_CHK_W'(r_base) + (w_double ? ((w_ext << 1) + c_CHK_W'(1)) : w_ext);
        w_oob = (w_end >= c_CHK_W'(c_TOTAL));
    end

    // Incremental next-element address: add inner step, or jump to next line
    always_comb begin
        w_xfer       = r_valid & req_ready;
        w_inner_end  = (r_inner == w_inner_max - c_DIM_W'(1));
        w_line_step  = r_line + w_outer_step;
        w_next_inner = w_inner_end ? '0 : r_inner + c_DIM_W'(1);
        w_next_outer = w_inner_end ? r_outer + c_DIM_W'(1) : r_outer;
        w_next_line  = w_inner_end ? w_line_step : r_line;
        w_next_cur   = w_inner_end ? w_line_step : r_cur + w_inner_step;
        w_next_last  = (w_next_inner == w_inner_max - c_DIM_W'(1)) &&
                       (w_next_outer == w_outer_max - c_DIM_W'(1));
        w_load_addr  = (r_state == c_S_CHECK) ? r_base : w_next_cur;
    end

    int_res_bank_decode #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_SIZE (BANK_SIZE),
        .ADDR_W    (ADDR_W),
        .BANK_W    (c_BANK_W),
        .BADDR_W   (c_BADDR_W)
    ) u_bank_decode (
        .flat_addr (w_load_addr),
        .bank      (w_dec_bank),
        .bank_addr (w_dec_baddr)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides everything including a transfer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start && !abort) w_state_nxt = c_S_CHECK;
            end
            c_S_CHECK: begin
                if (abort)        w_state_nxt = c_S_IDLE;
                else if (w_empty) w_state_nxt = c_S_FINISH;
                else if (w_oob)   w_state_nxt = c_S_IDLE;
                else              w_state_nxt = c_S_ISSUE;
            end
            c_S_ISSUE: begin
                if (abort)                 w_state_nxt = c_S_IDLE;
                else if (w_xfer && r_last) w_state_nxt = c_S_FINISH;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Datapath: latch tile, walk counters, register decoded request and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_stride <= '0;
            r_rows   <= '0;
            r_cols   <= '0;
            r_width  <= SINGLE_WIDTH;
            r_order  <= ROW_MAJOR;
            r_inner  <= '0;
            r_outer  <= '0;
            r_line   <= '0;
            r_cur    <= '0;
            r_bank   <= '0;
            r_baddr  <= '0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE && start && !abort) begin
                r_base   <= base_addr;
                r_stride <= row_stride;
                r_rows   <= num_rows;
                r_cols   <= num_cols;
                r_width  <= width;
                r_order  <= order;
            end

            if (r_state == c_S_CHECK) begin
                r_inner <= '0;
                r_outer <= '0;
                r_line  <= r_base;
                r_cur   <= r_base;
            end else if (r_state == c_S_ISSUE && w_xfer) begin
                r_inner <= w_next_inner;
                r_outer <= w_next_outer;
                r_line  <= w_next_line;
                r_cur   <= w_next_cur;
            end

            // Request fields only change on load or accepted transfer
            if (w_state_nxt == c_S_ISSUE && (r_state == c_S_CHECK || w_xfer)) begin
                r_bank  <= w_dec_bank;
                r_baddr <= w_dec_baddr;
            end

            if (w_state_nxt != c_S_ISSUE)
                r_last <= 1'b0;
            else if (r_state == c_S_CHECK)
                r_last <= (w_inner_max == c_DIM_W'(1)) && (w_outer_max == c_DIM_W'(1));
            else if (w_xfer)
                r_last <= w_next_last;

            r_valid <= (w_state_nxt == c_S_ISSUE);
            r_busy  <= (w_state_nxt != c_S_IDLE);
            r_done  <= (w_state_nxt == c_S_FINISH);
            r_err   <= (r_state == c_S_CHECK) && !abort && !w_empty && w_oob;
        end
    end

    assign req_valid = r_valid;
    assign req_bank  = r_bank;
    assign req_addr  = r_baddr;
    assign req_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire
